walker_ctrl: RTL and testbench
==============================

Name: walker_ctrl

Overview:
- Command-driven sequencer for the board LED bank.
- Accepts a valid/ready command carrying display mode, step period and sweep count, then steps the LEDs using an internal programmable step divider.
- Supports pause and abort; reports busy, a per-step strobe and a completion pulse.
- Sits between the top-level/UART command logic and the LED pins, replacing the free-running walker.

Parameters:
NLEDS, 7, number of LEDs driven; must be at least 2
DIV_W, 25, width of the step-period field and the divider counter
CNT_W, 8, width of the sweep-count field and the sweep counter

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command offered
o_cmd_ready  out  1  command can be accepted; high only in IDLE
i_cmd_mode  in  2  0=bounce walk, 1=wrap walk, 2=blink, 3=hold
i_cmd_period  in  DIV_W  clocks per step; 0 is treated as 1
i_cmd_sweeps  in  CNT_W  sweeps to run; 0 means run forever
i_cmd_pattern  in  NLEDS  pattern for blink and hold modes
i_pause  in  1  level; freezes stepping while high
i_abort  in  1  pulse or level; cancels the running command
o_led  out  NLEDS  LED drive
o_busy  out  1  high in RUN or PAUSE
o_step  out  1  one-cycle pulse on each step
o_done  out  1  one-cycle pulse when the sweep count completes

Behaviour:
Reset values (asynchronous, while i_rst_n=0):
- state=IDLE, o_led=1 (bit 0 lit), o_cmd_ready=1.
- o_busy=0, o_step=0, o_done=0.
- Divider, position and sweep counters all 0.

States:
- IDLE: ready=1, busy=0, o_led holds its value.
- RUN: busy=1.
- PAUSE: busy=1, all counters frozen, o_led held.

Command accept (i_cmd_valid && o_cmd_ready):
- Latch mode, period (max(period,1)), sweeps and pattern.
- Clear divider and position; load the sweep counter.
- Next cycle: state=RUN and o_led = position-0 value for the mode.

Position-0 value per mode:
- Modes 0 and 1: one-hot bit 0.
- Mode 2: the pattern.
- Mode 3: the pattern.

Step timing:
- In RUN the divider increments every clock.
- When divider == period-1: divider resets to 0, position advances, o_led updates, and o_step=1 that same cycle (registered with o_led).
- Step interval is therefore exactly "period" clocks.
- First step occurs "period" clocks after the first RUN cycle.

Position sequence (steps per sweep):
- Mode 0 (bounce): one-hot bit index 0,1,…,NLEDS-1,NLEDS-2,…,1, then repeats. 2*(NLEDS-1)=12 steps per sweep.
- Mode 1 (wrap): one-hot 0,1,…,NLEDS-1, then repeats. NLEDS steps per sweep.
- Mode 2 (blink): pattern, 0, pattern, 0, … 2 steps per sweep.
- Mode 3 (hold): pattern constant. 1 step per sweep; o_step still pulses.

Sweep completion:
- A sweep completes on the step that returns position to 0.
- If sweeps != 0: decrement on each completion.
- On completing the final sweep: same cycle o_done=1, o_step=1, o_led = position-0 value; next cycle state=IDLE.
- Sweeps=0: never completes.

Pause:
- In RUN with i_pause=1: enter PAUSE next cycle. A step due in that cycle still occurs.
- In PAUSE with i_pause=0: return to RUN; the divider continues from its frozen value.
- i_pause in IDLE has no effect.

Abort:
- In RUN or PAUSE: next cycle state=IDLE, o_led=0, no o_done, no o_step.
- Abort has priority over step, done and pause in the same cycle.
- In IDLE, abort is ignored; a simultaneous command is accepted.

Ready rules:
- Commands are never accepted outside IDLE.
- o_cmd_ready deasserts the cycle after accept and reasserts in the first IDLE cycle.
- Back-to-back accept is allowed: a command held valid is taken the cycle after o_done's following IDLE entry.

Reset mid-operation:
- Immediate return to reset values; the latched command is discarded.

Width rules:
- Divider compare is DIV_W unsigned.
- Position counter is sized for 2*(NLEDS-1) steps.
- The sweep counter does not wrap: it stops at 0 in finite mode.

Test Plan:
1. After reset: o_led=7'b0000001, ready=1, busy=0. Command mode 0, period 3, sweeps 1 → o_step every 3 clocks. o_led goes 01,02,04,08,10,20,40,20,10,08,04,02,01. o_done on the 12th step, 36 clocks after the first RUN cycle. Then IDLE, ready=1.
2. Mode 1, period 0 (treated as 1), sweeps 2 → o_led steps every clock: 01…40,01…40,01. o_done on step 14. Busy is high for exactly 14 clocks after accept.
3. Mode 2, pattern 7'h55, period 2, sweeps 3 → o_led alternates 55/00, ending 55. o_done on step 6. i_cmd_valid held through the run is not accepted until IDLE.
4. Mode 0, period 4, sweeps 0. Assert i_pause for 10 clocks mid-interval → no o_step and o_led frozen during pause. After release, the next step lands the remaining divider count later; total interval is 4+10 clocks.
5. Running mode 1: assert i_abort and i_pause in the same cycle a step is due → next cycle IDLE, o_led=0, o_done=0, o_step=0. An abort together with a new command in IDLE: the command is accepted.
6. Deassert i_rst_n asynchronously mid-run between clock edges → outputs immediately at reset values. After release, a new command runs normally from position 0.

Source files
------------

// File: rtl/walker_ctrl.sv
// walker_ctrl: command-driven LED sequencer.
// Takes a mode/period/sweeps/pattern command over valid/ready, then steps
// the LED bank once every "period" clocks until the sweep count completes,
// an abort arrives, or forever when sweeps is zero. Pause freezes everything.
module walker_ctrl #(
  parameter int NLEDS = 7,
  parameter int DIV_W = 25,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_mode,
  input  logic [DIV_W-1:0] i_cmd_period,
  input  logic [CNT_W-1:0] i_cmd_sweeps,
  input  logic [NLEDS-1:0] i_cmd_pattern,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic [NLEDS-1:0] o_led,
  output logic             o_busy,
  output logic             o_step,
  output logic             o_done
);

  // Longest sweep is the bounce walk; the position counter must also hold
  // the sweep length itself for the wrap comparison.
  localparam int BOUNCE_LEN = 2 * (NLEDS - 1);
  localparam int POS_W      = $clog2(BOUNCE_LEN + 1);
  localparam logic [NLEDS-1:0] LED_ONE  = {{(NLEDS-1){1'b0}}, 1'b1};
  localparam logic [NLEDS-1:0] LED_ZERO = {NLEDS{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  // Number of steps that make up one sweep in the given mode.
  function automatic logic [POS_W-1:0] sweep_len(input logic [1:0] mode);
    logic [POS_W-1:0] len;
    case (mode)
      2'd0:    len = POS_W'(BOUNCE_LEN);
      2'd1:    len = POS_W'(NLEDS);
      2'd2:    len = POS_W'(2);
      default: len = POS_W'(1);
    endcase
    return len;
  endfunction

  // LED image for a position within the sweep of the given mode.
  function automatic logic [NLEDS-1:0] led_at(input logic [1:0]       mode,
                                               input logic [NLEDS-1:0] pattern,
                                               input logic [POS_W-1:0] pos);
    logic [NLEDS-1:0] led;
    case (mode)
      2'd0: begin
        if (pos < POS_W'(NLEDS)) begin
          led = LED_ONE << pos;
        end else begin
          led = LED_ONE << (POS_W'(BOUNCE_LEN) - pos);
        end
      end
      2'd1:    led = LED_ONE << pos;
      2'd2:    led = (pos == {POS_W{1'b0}}) ? pattern : LED_ZERO;
      default: led = pattern;
    endcase
    return led;
  endfunction

  state_e             state_q,   state_d;
  logic [1:0]         mode_q,    mode_d;
  logic [DIV_W-1:0]   period_q,  period_d;
  logic [NLEDS-1:0]   pattern_q, pattern_d;
  logic [CNT_W-1:0]   sweeps_q,  sweeps_d;
  logic [DIV_W-1:0]   div_q,     div_d;
  logic [POS_W-1:0]   pos_q,     pos_d;
  logic [NLEDS-1:0]   led_q,     led_d;
  logic               step_q,    step_d;
  logic               done_q,    done_d;

  logic               step_due_s;
  logic [POS_W-1:0]   pos_inc_s;
  logic               wrap_s;
  logic [POS_W-1:0]   pos_next_s;
  logic               last_sweep_s;

  // Step decode from the current counters; period_q is never zero.
  always_comb begin
    step_due_s   = (div_q == (period_q - DIV_W'(1)));
    pos_inc_s    = pos_q + POS_W'(1);
    wrap_s       = (pos_inc_s == sweep_len(mode_q));
    pos_next_s   = wrap_s ? {POS_W{1'b0}} : pos_inc_s;
    last_sweep_s = wrap_s && (sweeps_q == CNT_W'(1));
  end

  // Next-state, counter and output computation for the sequencer.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    period_d  = period_q;
    pattern_d = pattern_q;
    sweeps_d  = sweeps_q;
    div_d     = div_q;
    pos_d     = pos_q;
    led_d     = led_q;
    step_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Abort is meaningless here, so a simultaneous command still wins.
        if (i_cmd_valid) begin
          mode_d    = i_cmd_mode;
          period_d  = (i_cmd_period == {DIV_W{1'b0}}) ? DIV_W'(1) : i_cmd_period;
          pattern_d = i_cmd_pattern;
          sweeps_d  = i_cmd_sweeps;
          div_d     = {DIV_W{1'b0}};
          pos_d     = {POS_W{1'b0}};
          led_d     = led_at(i_cmd_mode, i_cmd_pattern, {POS_W{1'b0}});
          state_d   = S_RUN;
        end else begin
          state_d   = S_IDLE;
        end
      end

      S_RUN: begin
        if (i_abort) begin
          led_d   = LED_ZERO;
          state_d = S_IDLE;
        end else begin
          if (step_due_s) begin
            div_d  = {DIV_W{1'b0}};
            pos_d  = pos_next_s;
            led_d  = led_at(mode_q, pattern_q, pos_next_s);
            step_d = 1'b1;
            if (wrap_s && (sweeps_q != {CNT_W{1'b0}})) begin
              sweeps_d = sweeps_q - CNT_W'(1);
            end else begin
              sweeps_d = sweeps_q;
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
          // Completion beats pause; a step due this cycle happens either way.
          if (step_due_s && last_sweep_s) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (i_pause) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_PAUSE: begin
        if (i_abort) begin
          led_d   = LED_ZERO;
          state_d = S_IDLE;
        end else if (!i_pause) begin
          state_d = S_RUN;
        end else begin
          state_d = S_PAUSE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state register with asynchronous reset to bit 0 lit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'd0;
      period_q  <= DIV_W'(1);
      pattern_q <= LED_ZERO;
      sweeps_q  <= {CNT_W{1'b0}};
      div_q     <= {DIV_W{1'b0}};
      pos_q     <= {POS_W{1'b0}};
      led_q     <= LED_ONE;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      pattern_q <= pattern_d;
      sweeps_q  <= sweeps_d;
      div_q     <= div_d;
      pos_q     <= pos_d;
      led_q     <= led_d;
      step_q    <= step_d;
      done_q    <= done_d;
    end
  end

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_led       = led_q;
  assign o_step      = step_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_walker_ctrl.sv
// tb_walker_ctrl: directed scenarios plus randomized traffic for walker_ctrl,
// checked every cycle against a time-based behavioural model.
module tb_walker_ctrl;
  localparam int NLEDS = 7;
  localparam int DIV_W = 25;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [DIV_W-1:0] cmd_period;
  logic [CNT_W-1:0] cmd_sweeps;
  logic [NLEDS-1:0] cmd_pattern;
  logic             pause;
  logic             abort;
  logic [NLEDS-1:0] led;
  logic             busy;
  logic             step;
  logic             done;

  always #5 clk = ~clk;

  walker_ctrl #(.NLEDS(NLEDS), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_mode(cmd_mode), .i_cmd_period(cmd_period),
    .i_cmd_sweeps(cmd_sweeps), .i_cmd_pattern(cmd_pattern),
    .i_pause(pause), .i_abort(abort),
    .o_led(led), .o_busy(busy), .o_step(step), .o_done(done)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Position is derived from the total number of RUN clocks since accept:
  // steps = run_clocks / period; LED = sequence[steps mod sweep length].
  bit               m_busy, m_paused;
  int               m_mode, m_period, m_sweeps, m_pattern, m_run;
  logic [NLEDS-1:0] e_led;
  bit               e_step, e_done;

  function automatic int seq_len(input int mode);
    case (mode)
      0:       return 2 * (NLEDS - 1);
      1:       return NLEDS;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int seq_val(input int mode, input int pat, input int i);
    case (mode)
      0:       return (i < NLEDS) ? (1 << i) : (1 << (2 * (NLEDS - 1) - i));
      1:       return 1 << i;
      2:       return (i % 2 == 0) ? pat : 0;
      default: return pat;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_paused = 0; m_run = 0;
    e_led = NLEDS'(1); e_step = 0; e_done = 0;
  endtask

  task automatic model_update();
    int k;
    e_step = 0; e_done = 0;
    if (!m_busy) begin
      if (cmd_valid) begin
        m_mode    = int'(cmd_mode);
        m_period  = (cmd_period == 0) ? 1 : int'(cmd_period);
        m_sweeps  = int'(cmd_sweeps);
        m_pattern = int'(cmd_pattern);
        m_run     = 0;
        m_busy    = 1;
        m_paused  = 0;
        e_led     = NLEDS'(seq_val(m_mode, m_pattern, 0));
      end
    end else if (abort) begin
      m_busy = 0; m_paused = 0; e_led = '0;
    end else if (m_paused) begin
      if (!pause) m_paused = 0;
    end else begin
      m_run++;
      if (m_run % m_period == 0) begin
        k      = m_run / m_period;
        e_step = 1;
        e_led  = NLEDS'(seq_val(m_mode, m_pattern, k % seq_len(m_mode)));
        if (m_sweeps != 0 && k == m_sweeps * seq_len(m_mode)) begin
          e_done = 1;
          m_busy = 0;
        end
      end
      if (m_busy && pause) m_paused = 1;
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("led",   32'(led),       32'(e_led));
    check("step",  32'(step),      32'(e_step));
    check("done",  32'(done),      32'(e_done));
    check("busy",  32'(busy),      32'(m_busy));
    check("ready", 32'(cmd_ready), 32'(!m_busy));
  end

  // One clock: the model sees the same inputs the DUT samples at this edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_cmd(input int mode, input int period, input int sweeps, input int pat);
    cmd_valid   = 1'b1;
    cmd_mode    = 2'(mode);
    cmd_period  = DIV_W'(period);
    cmd_sweeps  = CNT_W'(sweeps);
    cmd_pattern = NLEDS'(pat);
  endtask

  logic [NLEDS-1:0] t1_exp [12] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40,
                                    7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01};

  initial begin
    int idx, t, done_at, bc;
    logic [NLEDS-1:0] frozen;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_period = '0;
    cmd_sweeps = '0; cmd_pattern = '0; pause = 1'b0; abort = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_led",   32'(led), 32'h01);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: bounce walk, period 3, one sweep
    set_cmd(0, 3, 1, 0);
    cycle();
    cmd_valid = 1'b0;
    idx = 0; t = 0; done_at = -1;
    while (done_at < 0 && t < 100) begin
      cycle(); t++;
      if (step) begin
        if (idx < 12) check("t1_led", 32'(led), 32'(t1_exp[idx]));
        idx++;
      end
      if (done) done_at = t;
    end
    check("t1_done_cycle", 32'(done_at), 32'd36);
    check("t1_steps", 32'(idx), 32'd12);
    check("t1_ready", 32'(cmd_ready), 32'd1);

    // 2: wrap walk, period 0 (as 1), two sweeps
    set_cmd(1, 0, 2, 0);
    cycle();
    cmd_valid = 1'b0;
    bc = busy ? 1 : 0; idx = 0; done_at = -1; t = 0;
    while (busy && t < 100) begin
      cycle(); t++;
      if (step) idx++;
      if (done) done_at = idx;
      if (busy) bc++;
    end
    check("t2_busy_clocks", 32'(bc), 32'd14);
    check("t2_done_step", 32'(done_at), 32'd14);
    check("t2_final_led", 32'(led), 32'h01);

    // 3: blink 0x55, period 2, three sweeps, next command held valid throughout
    set_cmd(2, 2, 3, 'h55);
    cycle();
    set_cmd(3, 5, 1, 'h2A);
    idx = 0; t = 0; done_at = -1;
    while (done_at < 0 && t < 100) begin
      cycle(); t++;
      if (step) begin
        idx++;
        check("t3_led", 32'(led), (idx % 2 == 0) ? 32'h55 : 32'h00);
      end
      if (done) done_at = idx; else check("t3_ready_low", 32'(cmd_ready), 32'd0);
    end
    check("t3_done_step", 32'(done_at), 32'd6);
    cycle();
    cmd_valid = 1'b0;
    check("t3_next_busy", 32'(busy), 32'd1);
    check("t3_next_led", 32'(led), 32'h2A);
    abort = 1'b1; cycle(); abort = 1'b0;

    // 4: bounce forever, period 4, pause 10 clocks mid-interval
    set_cmd(0, 4, 0, 0);
    cycle();
    cmd_valid = 1'b0;
    t = 0;
    while (!step && t < 20) begin cycle(); t++; end
    check("t4_first_step", 32'(step), 32'd1);
    t = 0;
    cycle(); t++;
    pause = 1'b1; frozen = led;
    repeat (10) begin
      cycle(); t++;
      check("t4_pause_step", 32'(step), 32'd0);
      check("t4_pause_led", 32'(led), 32'(frozen));
    end
    pause = 1'b0;
    while (!step && t < 40) begin cycle(); t++; end
    check("t4_interval", 32'(t), 32'd14);
    check("t4_led", 32'(led), 32'h04);
    abort = 1'b1; cycle(); abort = 1'b0;

    // 5: abort + pause on a due step; then abort with a command in IDLE
    set_cmd(1, 3, 0, 0);
    cycle();
    cmd_valid = 1'b0;
    idx = 0; t = 0;
    while (idx < 2 && t < 30) begin cycle(); t++; if (step) idx++; end
    cycle(); cycle();
    abort = 1'b1; pause = 1'b1;
    cycle();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_led", 32'(led), 32'h00);
    check("t5_step", 32'(step), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    pause = 1'b0;
    set_cmd(3, 1, 1, 'h11);
    cycle();
    cmd_valid = 1'b0; abort = 1'b0;
    check("t5_accept_busy", 32'(busy), 32'd1);
    check("t5_accept_led", 32'(led), 32'h11);
    cycle();
    check("t5_hold_done", 32'(done), 32'd1);
    check("t5_hold_idle", 32'(busy), 32'd0);

    // 6: asynchronous reset mid-run
    set_cmd(0, 2, 0, 0);
    cycle();
    cmd_valid = 1'b0;
    repeat (5) cycle();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_led", 32'(led), 32'h01);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_step", 32'(step), 32'd0);
    check("t6_ready", 32'(cmd_ready), 32'd1);
    #2 rst_n = 1'b1;
    set_cmd(1, 1, 1, 0);
    cycle();
    cmd_valid = 1'b0;
    cycle();
    check("t6_first_step", 32'(step), 32'd1);
    check("t6_first_led", 32'(led), 32'h02);
    t = 0;
    while (busy && t < 20) begin cycle(); t++; end
    check("t6_idle", 32'(busy), 32'd0);

    // Randomized traffic, checked by the every-cycle compare
    for (int i = 0; i < 3000; i++) begin
      cmd_valid   = 1'($urandom % 2);
      cmd_mode    = 2'($urandom % 4);
      cmd_period  = DIV_W'($urandom % 5);
      cmd_sweeps  = CNT_W'($urandom % 3);
      cmd_pattern = NLEDS'($urandom);
      if ($urandom % 16 == 0) pause = ~pause;
      abort       = ($urandom % 40 == 0);
      cycle();
    end
    cmd_valid = 1'b0; pause = 1'b0; abort = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
